instr_sequencer: RTL and testbench

Upstream control stage for `Processor`. It holds a small program of 24-bit instructions and steps through them after a start pulse. For each instruction it drives Processor's `A`, `B`, `opcode`, `write_addr`, `write_enable` and `read_addr`. It also captures Processor's `read_data` for READ instructions, so ALU-and-store sequences run without a bench hand-driving each step.

---
 rtl/instr_sequencer.sv | 135 +++++++++++++
 tb/tb_instr_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: steps a small 24-bit program through Processor's
// ALU and register file, capturing READ results.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [23:0]   load_data,
  input  logic [7:0]    read_data,
  output logic [7:0]    A,
  output logic [7:0]    B,
  output logic [1:0]    opcode,
  output logic [2:0]    write_addr,
  output logic          write_enable,
  output logic [2:0]    read_addr,
  output logic [7:0]    result,
  output logic          result_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_RWAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_ALU,
    K_NOP,
    K_READ,
    K_HALT
  } kind_t;

  state_t state;
  kind_t  kind;

  logic [23:0] mem [DEPTH];
  logic [23:0] ir;
  logic        last;
  logic        unused_rsvd;

  assign ir          = mem[pc];
  assign unused_rsvd = ir[19];
  assign last        = (pc == AW'(DEPTH - 1));

  assign busy         = (state != S_IDLE);
  assign write_enable = (state == S_EXEC) && (kind == K_ALU);

  // Program memory survives reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (!reset && load_en && state == S_IDLE)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      kind         <= K_NOP;
      A            <= '0;
      B            <= '0;
      opcode       <= '0;
      write_addr   <= '0;
      read_addr    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      pc           <= '0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          kind  <= kind_t'(ir[23:22]);
          state <= S_EXEC;
          unique case (1'b1)
            (ir[23:22] == 2'b00): begin
              opcode     <= ir[21:20];
              write_addr <= ir[18:16];
              A          <= ir[15:8];
              B          <= ir[7:0];
            end
            (ir[23:22] == 2'b10): read_addr <= ir[18:16];
            default: ;
          endcase
        end
        S_EXEC: begin
          unique case (1'b1)
            (kind == K_READ): state <= S_RWAIT;
            (kind == K_HALT): begin
              state <= S_DONE;
              done  <= 1'b1;
            end
            default: begin
              if (last) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                pc    <= pc + AW'(1);
                state <= S_FETCH;
              end
            end
          endcase
        end
        S_RWAIT: begin
          result       <= read_data;
          result_valid <= 1'b1;
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            pc    <= pc + AW'(1);
            state <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random programs against an
// instruction-level model plus a behavioural Processor register file.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [23:0] load_data;
  logic [7:0]  read_data;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [1:0]  opcode;
  logic [2:0]  write_addr;
  logic        write_enable;
  logic [2:0]  read_addr;
  logic [7:0]  result;
  logic        result_valid;
  logic        busy;
  logic        done;
  logic [3:0]  pc;

  instr_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .read_data    (read_data),
    .A            (A),
    .B            (B),
    .opcode       (opcode),
    .write_addr   (write_addr),
    .write_enable (write_enable),
    .read_addr    (read_addr),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done),
    .pc           (pc)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [23:0] prog [16];
  logic [7:0]  rf   [8];
  logic [7:0]  rfm  [8];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_obs [$];
  int          exp_done;
  int          exp_we;
  int          exp_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] aluf(input logic [1:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  // Behavioural Processor: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (reset) rf <= '{default: 8'h00};
    else if (write_enable) rf[write_addr] <= aluf(opcode, A, B);
  end
  assign read_data = rf[read_addr];

  function automatic logic [23:0] mk(input logic [1:0] k,
                                     input logic [1:0] op,
                                     input logic [2:0] r,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    return {k, op, 1'b0, r, a, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: walks the program, tallies cycles.
  task automatic model();
    int p;
    int cyc;
    bit halt;
    logic [23:0] w;
    exp_q.delete();
    exp_we = 0;
    cyc = 0;
    p = 0;
    halt = 0;
    for (int n = 0; n < 16; n++) begin
      w = prog[p];
      case (w[23:22])
        2'b00: begin
          rfm[w[18:16]] = aluf(w[21:20], w[15:8], w[7:0]);
          exp_we++;
          cyc += 2;
        end
        2'b01: cyc += 2;
        2'b10: begin
          exp_q.push_back(rfm[w[18:16]]);
          cyc += 3;
        end
        default: begin
          cyc += 2;
          halt = 1;
        end
      endcase
      if (halt || p == 15) break;
      p++;
    end
    exp_done = cyc + 1;
    exp_pc   = p;
  endtask

  task automatic load(input logic [3:0] a, input logic [23:0] w);
    load_en   = 1'b1;
    load_addr = a;
    load_data = w;
    prog[a]   = w;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int inject_at,
                          input bit with_load0);
    int cyc;
    int we_n;
    int we_pair;
    int gap;
    bit prev_we;
    bit got;
    logic [3:0] pc_at;
    model();
    last_obs.delete();
    start = 1'b1;
    if (with_load0) begin
      load_en   = 1'b1;
      load_addr = 4'd0;
      load_data = prog[0];
    end
    @(posedge clk); #1;
    start   = 1'b0;
    load_en = 1'b0;
    cyc = 1; we_n = 0; we_pair = 0; gap = 0;
    prev_we = 0; got = 0; pc_at = 'x;
    while (cyc <= 200) begin
      if (!busy) gap++;
      if (write_enable) we_n++;
      if (write_enable && prev_we) we_pair++;
      prev_we = write_enable;
      if (result_valid) last_obs.push_back(result);
      if (done) begin
        got   = 1;
        pc_at = pc;
        break;
      end
      if (cyc == inject_at) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = mk(2'b11, 2'b00, 3'd0, 8'h00, 8'h00);
      end
      @(posedge clk); #1;
      start   = 1'b0;
      load_en = 1'b0;
      cyc++;
    end
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_done));
    chk({tag, " pc_at_done"}, 64'(pc_at), 64'(exp_pc));
    chk({tag, " we_cycles"}, 64'(we_n), 64'(exp_we));
    chk({tag, " we_back2back"}, 64'(we_pair), 64'd0);
    chk({tag, " busy_gap"}, 64'(gap), 64'd0);
    chk({tag, " result_count"}, 64'(last_obs.size()),
        64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < last_obs.size(); i++)
      chk({tag, " result"}, 64'(last_obs[i]), 64'(exp_q[i]));
    @(posedge clk); #1;
    chk({tag, " after_done"}, 64'({done, busy}), 64'd0);
  endtask

  function automatic logic [39:0] out_vec();
    return {A, B, opcode, write_addr, read_addr, write_enable,
            result, result_valid, busy, done, pc};
  endfunction

  initial begin
    logic [7:0] four_exp [4];
    int k;
    four_exp = '{8'hEE, 8'h77, 8'h11, 8'h88};
    reset = 1'b1; start = 1'b0; load_en = 1'b0;
    load_addr = '0; load_data = '0;
    rfm = '{default: 8'h00};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_values", 64'(out_vec()), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Store AND then read it back
    for (int i = 0; i < 16; i++) load(4'(i), mk(2'b11, 0, 0, 0, 0));
    load(4'd0, mk(2'b00, 2'b00, 3'd0, 8'hCC, 8'hAA));
    load(4'd1, mk(2'b10, 2'b00, 3'd0, 8'h00, 8'h00));
    run_prog("store_and", -1, 0);
    chk("and_const", 64'(last_obs[0]), 64'h88);

    // All four ops
    load(4'd0, mk(2'b00, 2'b01, 3'd1, 8'hCC, 8'hAA));
    load(4'd1, mk(2'b00, 2'b10, 3'd2, 8'hCC, 8'hAA));
    load(4'd2, mk(2'b00, 2'b11, 3'd3, 8'hCC, 8'hAA));
    load(4'd3, mk(2'b00, 2'b00, 3'd4, 8'hCC, 8'hAA));
    for (int i = 0; i < 4; i++)
      load(4'(4 + i), mk(2'b10, 0, 3'(i + 1), 0, 0));
    load(4'd8, mk(2'b11, 0, 0, 0, 0));
    run_prog("four_ops", -1, 0);
    for (int i = 0; i < 4; i++)
      chk("four_const", 64'(last_obs[i]), 64'(four_exp[i]));

    // Busy-time start/load must be ignored
    run_prog("ignored_req", 5, 0);
    run_prog("rerun", -1, 0);

    // Reset during EXEC of an ALU instruction
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("exec_we_before_reset", 64'(write_enable), 64'd1);
    reset = 1'b1;
    #1;
    chk("reset_mid_exec", 64'(out_vec()), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rfm = '{default: 8'h00};
    @(posedge clk); #1;
    run_prog("after_reset", -1, 0);

    // Full program of NOPs, no wrap
    for (int i = 0; i < 16; i++) load(4'(i), mk(2'b01, 0, 0, 0, 0));
    run_prog("nop_full", -1, 0);
    chk("nop_done_33", 64'(exp_done), 64'd33);

    // Random programs; word 0 arrives together with start
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) begin
        k = $urandom_range(0, 9);
        prog[i] = mk(k < 4 ? 2'b00 : k < 6 ? 2'b01 : k < 9 ? 2'b10 : 2'b11,
                     2'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
        if (i > 0) load(4'(i), prog[i]);
      end
      run_prog("random", -1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
